// File: rtl/hack_data_mem_if.sv
// CPU data bus, keyboard input and display write-port signals of the HACK data memory.
interface hack_data_mem_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        scr_valid;
  logic        scr_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;

  modport master (
    output addressM, outM, writeM, kbd_valid, kbd_code, scr_ready,
    input  inM, scr_valid, scr_addr, scr_data
  );

  modport slave (
    input  addressM, outM, writeM, kbd_valid, kbd_code, scr_ready,
    output inM, scr_valid, scr_addr, scr_data
  );
endinterface

// File: rtl/hack_data_mem.sv
// HACK data memory: RAM, queued screen writes to an external display, keyboard and status.
// Define SCREEN_SHADOW_EN to add a readable 8K x 16 shadow of the screen region.
module hack_data_mem #(
  parameter int unsigned RAM_AW  = 14,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  hack_data_mem_if.slave  bus
);

  localparam int unsigned     Depth    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

  logic [15:0] ram [2 ** RAM_AW];
  logic [28:0] fifoMem [Depth];

  logic [FIFO_AW-1:0] rdPtrQ, wrPtrQ;
  logic [FIFO_AW:0]   cntQ;
  logic               ovfQ;
  logic [15:0]        kbdQ;

  logic isRam, isScreen, isKbd, isStatus;
  logic empty, full, pop, pushReq, push, drop, ovfClr;
  logic [15:0] status, screenRd;
  logic [28:0] head;

  assign isRam    = ~bus.addressM[14];
  assign isScreen = bus.addressM[14:13] == 2'b10;
  assign isKbd    = bus.addressM == 15'h6000;
  assign isStatus = bus.addressM == 15'h6001;

  assign empty   = cntQ == '0;
  assign full    = cntQ == DepthCnt;
  assign pop     = ~empty & bus.scr_ready;
  assign pushReq = bus.writeM & isScreen;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push    = pushReq & (~full | pop);
  assign drop    = pushReq & ~push;
  assign ovfClr  = bus.writeM & isStatus & bus.outM[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtrQ <= '0;
      wrPtrQ <= '0;
      cntQ   <= '0;
      ovfQ   <= 1'b0;
      kbdQ   <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
      cntQ <= cntQ + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
      if (drop) begin
        ovfQ <= 1'b1;
      end else if (ovfClr) begin
        ovfQ <= 1'b0;
      end
      if (bus.kbd_valid) kbdQ <= bus.kbd_code;
    end
  end

  // Storage arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtrQ] <= {bus.addressM[12:0], bus.outM};
  end

  always_ff @(posedge clk) begin
    if (bus.writeM && isRam) ram[bus.addressM[RAM_AW-1:0]] <= bus.outM;
  end

`ifdef SCREEN_SHADOW_EN
  logic [15:0] shadow [8192];

  always_ff @(posedge clk) begin
    if (push) shadow[bus.addressM[12:0]] <= bus.outM;
  end

  assign screenRd = shadow[bus.addressM[12:0]];
`else
  assign screenRd = '0;
`endif

  assign head          = fifoMem[rdPtrQ];
  assign bus.scr_valid = ~empty;
  assign bus.scr_addr  = head[28:16];
  assign bus.scr_data  = head[15:0];

  always_comb begin
    status              = '0;
    status[15]          = ovfQ;
    status[14]          = full;
    status[13]          = empty;
    status[FIFO_AW:0]   = cntQ;
  end

  always_comb begin
    bus.inM = '0;
    if (isRam) begin
      bus.inM = ram[bus.addressM[RAM_AW-1:0]];
    end else if (isScreen) begin
      bus.inM = screenRd;
    end else if (isKbd) begin
      bus.inM = kbdQ;
    end else if (isStatus) begin
      bus.inM = status;
    end
  end

endmodule

// File: tb/tb_hack_data_mem.sv
// Randomised bench for hack_data_mem: reference model of the memory map plus a display-side
// scoreboard that checks every entry the FIFO hands out.
module tb_hack_data_mem;

  logic clk = 1'b0;
  logic rst;
  hack_data_mem_if bus ();

  hack_data_mem #(
    .RAM_AW (14),
    .FIFO_AW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Reference model state
  logic [15:0] mRam    [int];
  logic [15:0] mShadow [int];
  logic [15:0] mKbd;
  logic        mOvf;
  int          mCount;
  logic [28:0] sbq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit expRead(input logic [14:0] a, output logic [15:0] v);
    v = '0;
    if (a < 15'h4000) begin
      if (!mRam.exists(int'(a))) return 1'b0;
      v = mRam[int'(a)];
    end else if (a < 15'h6000) begin
`ifdef SCREEN_SHADOW_EN
      if (!mShadow.exists(int'(a[12:0]))) return 1'b0;
      v = mShadow[int'(a[12:0])];
`else
      v = 16'h0000;
`endif
    end else if (a == 15'h6000) begin
      v = mKbd;
    end else if (a == 15'h6001) begin
      v = (mOvf ? 16'h8000 : 16'h0000) | (mCount == 16 ? 16'h4000 : 16'h0000) |
          (mCount == 0 ? 16'h2000 : 16'h0000) | 16'(mCount);
    end
    return 1'b1;
  endfunction

  // One bus cycle: drive, check outputs mid-cycle, advance the model, cross the edge.
  task automatic step(input logic [14:0] a, input logic [15:0] d, input logic we,
                      input logic kv, input logic [15:0] kc, input logic rdy);
    logic [15:0] ev;
    bit pop, scrW, acc;
    bus.addressM  = a;
    bus.outM      = d;
    bus.writeM    = we;
    bus.kbd_valid = kv;
    bus.kbd_code  = kc;
    bus.scr_ready = rdy;
    @(negedge clk);
    if (expRead(a, ev)) chk("inM", {16'h0, bus.inM}, {16'h0, ev});
    chk("scr_valid", {31'h0, bus.scr_valid}, {31'h0, mCount != 0});
    #1;
    pop  = (mCount > 0) && rdy;
    scrW = we && (a >= 15'h4000) && (a < 15'h6000);
    acc  = scrW && ((mCount < 16) || pop);
    if (scrW && !acc) mOvf = 1'b1;
    else if (we && a == 15'h6001 && d[15]) mOvf = 1'b0;
    mCount = mCount + (acc ? 1 : 0) - (pop ? 1 : 0);
    if (acc) begin
      sbq.push_back({a[12:0], d});
      mShadow[int'(a[12:0])] = d;
    end
    if (we && a < 15'h4000) mRam[int'(a)] = d;
    if (kv) mKbd = kc;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    sbq.delete();
    mCount = 0;
    mOvf   = 1'b0;
    mKbd   = 16'h0000;
  endtask

  // Display-side monitor: every accepted head entry must match the scoreboard front.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.scr_valid === 1'b1 && bus.scr_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL scr pop: got %h/%h, expected no entry", bus.scr_addr, bus.scr_data);
      end else begin
        logic [28:0] exp;
        exp = sbq.pop_front();
        chk("scr entry", {3'b0, bus.scr_addr, bus.scr_data}, {3'b0, exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", nTests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] a;
    logic [15:0] d;
    int cls;

    rst           = 1'b1;
    bus.addressM  = 15'h6001;
    bus.outM      = '0;
    bus.writeM    = 1'b0;
    bus.kbd_valid = 1'b0;
    bus.kbd_code  = '0;
    bus.scr_ready = 1'b0;
    modelReset();
    #1;
    chk("reset status", {16'h0, bus.inM}, 32'h2000);
    chk("reset scr_valid", {31'h0, bus.scr_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // RAM write then read-back, screen read without shadow
    step(15'h0005, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0);
    step(15'h0005, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("ram readback", {16'h0, bus.inM}, 32'h1234);
    step(15'h4005, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);

    // Back-pressure: entry appears one edge later and holds while not ready
    step(15'h4010, 16'hAAAA, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp scr_valid", {31'h0, bus.scr_valid}, 32'h1);
      chk("bp scr_addr", {19'h0, bus.scr_addr}, 32'h0010);
      chk("bp scr_data", {16'h0, bus.scr_data}, 32'hAAAA);
      step(15'h0005, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    end
    step(15'h0005, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("bp drained", {31'h0, bus.scr_valid}, 32'h0);

    // Overflow: 17 writes into a stalled FIFO
    for (int i = 0; i < 17; i++) begin
      step(15'h4000 + 15'(i), 16'($urandom), 1'b1, 1'b0, 16'h0, 1'b0);
    end
    step(15'h6001, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("status overflow", {16'h0, bus.inM}, 32'hC010);
    step(15'h6001, 16'h8000, 1'b1, 1'b0, 16'h0, 1'b0);
    step(15'h6001, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("status ovf cleared", {16'h0, bus.inM}, 32'h4010);

    // Full FIFO with simultaneous push and pop
    step(15'h4123, 16'h5A5A, 1'b1, 1'b0, 16'h0, 1'b1);
    step(15'h6001, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("status full push/pop", {16'h0, bus.inM}, 32'h4010);

    // Keyboard latch
    step(15'h0000, 16'h0000, 1'b0, 1'b1, 16'h0041, 1'b0);
    step(15'h6000, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("kbd 0x41", {16'h0, bus.inM}, 32'h0041);
    step(15'h6000, 16'hFFFF, 1'b1, 1'b0, 16'h0, 1'b0);
    step(15'h6000, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("kbd write ignored", {16'h0, bus.inM}, 32'h0041);
    step(15'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0);
    step(15'h6000, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("kbd cleared", {16'h0, bus.inM}, 32'h0000);

    // Randomised traffic across the whole map
    for (int n = 0; n < 400; n++) begin
      cls = int'($urandom_range(0, 9));
      if (cls <= 3)      a = 15'($urandom_range(0, 31));
      else if (cls <= 6) a = 15'h4000 + 15'($urandom_range(0, 8191));
      else if (cls == 7) a = 15'h6000;
      else if (cls == 8) a = 15'h6001;
      else               a = 15'h6002 + 15'($urandom_range(0, 16'h1FFD));
      d = 16'($urandom);
      step(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 16'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-cycle with entries pending
    for (int i = 0; i < 5; i++) begin
      step(15'h4100 + 15'(i), 16'($urandom), 1'b1, 1'b0, 16'h0, 1'b0);
    end
    #2;
    rst          = 1'b1;
    bus.addressM = 15'h6001;
    bus.writeM   = 1'b0;
    #1;
    chk("async rst scr_valid", {31'h0, bus.scr_valid}, 32'h0);
    chk("async rst status", {16'h0, bus.inM}, 32'h2000);
    modelReset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(15'h0005, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
    step(15'h6001, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1);

    // Drain whatever is left and make sure nothing went missing
    step(15'h4ABC, 16'hC0DE, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 64 && mCount > 0; i++) begin
      step(15'h6001, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1);
    end
    chk("scoreboard drained", sbq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/hack_data_mem.md
# hack_data_mem

Data-side memory responder for the HACK CPU: services the CPU's `addressM`/`outM`/`writeM` requests and returns `inM`. Decodes the HACK memory map into general RAM, a screen region whose writes are queued in a FIFO and drained to an external display over a valid/ready handshake, a keyboard register, and a status register. It sits between the CPU and the display/keyboard peripherals, alongside the instruction ROM.

## Interface
Parameters:
- `RAM_AW`, 14, RAM address width; RAM depth is 2^RAM_AW words, and 14 gives 16K words.
- `FIFO_AW`, 4, screen FIFO address width; depth is 2^FIFO_AW, and 4 gives 16 entries.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `addressM`  input  15  CPU data address.
- `outM`  input  16  CPU write data.
- `writeM`  input  1  CPU write strobe, sampled on the rising edge.
- `inM`  output  16  read data, combinational from `addressM`.
- `kbd_valid`  input  1  keyboard code strobe.
- `kbd_code`  input  16  keyboard scan code; 0 means no key.
- `scr_valid`  output  1  display write pending.
- `scr_ready`  input  1  display accepts the head entry.
- `scr_addr`  output  13  screen word offset of the head entry.
- `scr_data`  output  16  pixel word of the head entry.

## Operation
Memory map on `addressM`:
- 0x0000–0x3FFF: RAM.
  - Synchronous write, asynchronous read.
  - Address bits above RAM_AW are ignored, so the region aliases.
  - RAM contents are not reset.
- 0x4000–0x5FFF: screen.
  - A write pushes {addressM[12:0], outM} into the FIFO.
  - A read returns 0x0000, unless `SCREEN_SHADOW_EN` is defined (see Configuration).
- 0x6000: keyboard.
  - Read returns the kbd latch.
  - Writes are ignored.
  - The latch loads `kbd_code` on every cycle where `kbd_valid`=1.
- 0x6001: status.
  - Read layout: bit15 = overflow (sticky), bit14 = full, bit13 = empty, bits[FIFO_AW:0] = count, all other bits 0.
  - A write with outM[15]=1 clears overflow; all other written bits are ignored.
- 0x6002–0x7FFF: reads return 0x0000; writes are ignored.

FIFO:
- `scr_valid` = !empty.
- `scr_addr` and `scr_data` present the head entry.
- Pop occurs when `scr_valid` && `scr_ready`.
- Push is accepted when count < depth, or when a pop occurs in the same cycle.
- When full with no pop, the push is dropped and overflow is set.
- Overflow set and clear in the same cycle: set wins.
- Read and write pointers wrap modulo depth. Count is held in FIFO_AW+1 bits.

## Timing
- Reset values:
  - `scr_valid`=0; FIFO empty, count=0, pointers=0.
  - kbd latch=0x0000; overflow=0.
  - `inM` follows the decode with reset state, so status reads 0x2000.
- Read latency is 0 cycles: `inM` is valid in the same cycle `addressM` is presented. This is required by the single-cycle CPU.
- Write latency is 1 edge. A RAM read of the same address in the next cycle returns the new data.
- A pushed entry appears on `scr_*` one edge after the push when the FIFO was empty. There is no fall-through in the same cycle.
- While `scr_valid`=1 && `scr_ready`=0, `scr_addr` and `scr_data` hold stable.
- Simultaneous push and pop when full: both occur and count is unchanged. When empty, only the push occurs; pop is impossible.
- Reset asserted mid-operation empties the FIFO immediately and discards pending entries. RAM contents are unaffected.

## Configuration
- `SCREEN_SHADOW_EN` defined:
  - Adds an 8K×16 shadow RAM, written on every accepted screen write.
  - Screen-region reads return shadow contents.
  - Dropped (overflow) writes do not update the shadow.
- Undefined: no shadow RAM; screen-region reads return 0x0000.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle, then read 0x6001 → `inM`=0x2000; `scr_valid`=0 with no clock edge required.
- **RAM write/read:** write 0x1234 to 0x0005, then read 0x0005 next cycle → 0x1234. Read 0x4005 with shadow off → 0x0000.
- **Screen FIFO with back-pressure:**
  - Hold `scr_ready`=0 and write 0xAAAA to 0x4010 → next cycle `scr_valid`=1, `scr_addr`=0x0010, `scr_data`=0xAAAA.
  - Outputs stay stable over 5 cycles.
  - Raise `scr_ready` → pop, then `scr_valid`=0.
- **Overflow:**
  - With `scr_ready`=0, do 17 screen writes → status = 0xC000|16 (overflow, full, count=16); the 17th entry is never emitted.
  - Write 0x8000 to 0x6001 → overflow clears, giving status 0x4010.
- **Full with simultaneous push/pop:** with FIFO full and `scr_ready`=1, write a screen word → count stays 16, overflow stays 0, and the new entry eventually emerges in order.
- **Keyboard:**
  - Pulse `kbd_valid` with `kbd_code`=0x0041, then read 0x6000 → 0x0041.
  - Write to 0x6000 → value unchanged.
  - Pulse `kbd_valid` with 0x0000 → read returns 0x0000.
